if_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register and upstream of the IF/ID pipeline register. It samples the current PC and reads the 32-bit instruction as four little-endian byte reads over the shared 8-bit memory port, through the memory arbiter. It delivers `{inst, pc}` with a valid/stall handshake. It raises a stall request to the pipeline controller while a fetch is in flight, and aborts cleanly on a branch flush.

---
 rtl/if_fetch.sv | 153 +++++++++++++++
 tb/tb_if_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit little-endian instruction from four
// byte reads on the shared memory port and presents {inst, pc} with a valid/stall handshake.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [2:0]        rcv_cnt_q, rcv_cnt_d;
  logic              rsp_pending_q, rsp_pending_d;
  logic              mem_req_q, mem_req_d;
  logic              inst_valid_q, inst_valid_d;

  logic [ADDR_W-1:0] pc_aligned;
  logic [2:0]        issue_inc;
  logic              granted;

  assign pc_aligned = pc_i & ~ADDR_W'(3);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    mem_addr_d    = mem_addr_q;
    inst_pc_d     = inst_pc_q;
    buf_d         = buf_q;
    inst_d        = inst_q;
    issue_cnt_d   = issue_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    rsp_pending_d = rsp_pending_q;
    mem_req_d     = mem_req_q;
    inst_valid_d  = inst_valid_q;
    issue_inc     = issue_cnt_q + 3'd1;
    granted       = 1'b0;

    if (flush_i) begin
      // Clearing rsp_pending drops any byte still in flight from the aborted fetch.
      state_d       = IDLE;
      inst_valid_d  = 1'b0;
      issue_cnt_d   = 3'd0;
      rcv_cnt_d     = 3'd0;
      rsp_pending_d = 1'b0;
      mem_req_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          base_d        = pc_aligned;
          mem_addr_d    = pc_aligned;
          mem_req_d     = 1'b1;
          issue_cnt_d   = 3'd0;
          rcv_cnt_d     = 3'd0;
          rsp_pending_d = 1'b0;
          state_d       = BUSY;
        end
        BUSY: begin
          granted       = mem_req_q && mem_gnt_i;
          rsp_pending_d = granted;
          if (granted) begin
            issue_cnt_d = issue_inc;
            mem_req_d   = (issue_inc < 3'd4);
            if (issue_inc < 3'd4) begin
              mem_addr_d = base_q + ADDR_W'(issue_inc);
            end
          end
          if (rsp_pending_q) begin
            buf_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_rdata_i;
            rcv_cnt_d = rcv_cnt_q + 3'd1;
            if (rcv_cnt_q == 3'd3) begin
              inst_d       = {mem_rdata_i, buf_q[INST_W-9:0]};
              inst_pc_d    = base_q;
              inst_valid_d = 1'b1;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          // Consumption starts the next fetch immediately, skipping IDLE.
          if (!stall_i) begin
            base_d        = pc_aligned;
            mem_addr_d    = pc_aligned;
            mem_req_d     = 1'b1;
            issue_cnt_d   = 3'd0;
            rcv_cnt_d     = 3'd0;
            rsp_pending_d = 1'b0;
            inst_valid_d  = 1'b0;
            state_d       = BUSY;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      mem_addr_q    <= '0;
      inst_pc_q     <= '0;
      buf_q         <= '0;
      inst_q        <= '0;
      issue_cnt_q   <= 3'd0;
      rcv_cnt_q     <= 3'd0;
      rsp_pending_q <= 1'b0;
      mem_req_q     <= 1'b0;
      inst_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      mem_addr_q    <= mem_addr_d;
      inst_pc_q     <= inst_pc_d;
      buf_q         <= buf_d;
      inst_q        <= inst_d;
      issue_cnt_q   <= issue_cnt_d;
      rcv_cnt_q     <= rcv_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      mem_req_q     <= mem_req_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign stall_req_o  = (state_q != HOLD);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-memory responder, scoreboard of expected {inst, pc},
// and per-scenario tasks checking latency, address sequences and control outputs.
module tb_if_fetch;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  typedef logic [31:0] addr_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stall_req_o;

  int      n_cmp = 0;
  int      n_bad = 0;
  int      edge_cnt = 0;
  logic    valid_prev = 1'b0;
  logic    rose = 1'b0;
  exp_t    sb[$];
  addr_q_t req_log;
  addr_q_t gnt_log;
  logic [31:0] skip_addr = 32'hFFFF_FFFF;
  int      skip_n = 0;

  if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rdata_i(mem_rdata_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h00;
      32'h2: return 8'h50;
      32'h3: return 8'h00;
      default: return 8'(a * 32'd37 + (a >> 8) + 32'd11);
    endcase
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] b);
    return {mem_rd(b + 32'd3), mem_rd(b + 32'd2), mem_rd(b + 32'd1), mem_rd(b)};
  endfunction

  function automatic logic [255:0] pack_log(input addr_q_t q);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < q.size() && i < 8; i++) r[i*32 +: 32] = q[i];
    return r;
  endfunction

  function automatic void push_exp(input logic [31:0] b);
    exp_t e;
    e.inst = exp_inst(b);
    e.pc   = b;
    sb.push_back(e);
  endfunction

  // One clock: sample grant before the edge, return the read byte on the following negedge,
  // and pop/compare the scoreboard whenever inst_valid_o rises.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    exp_t        e;
    g = mem_req_o && mem_gnt_i;
    a = mem_addr_o;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    mem_rdata_i = g ? mem_rd(a) : 8'($urandom);
    rose = inst_valid_o && !valid_prev;
    valid_prev = inst_valid_o;
    if (rose) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got inst=%h pc=%h, required no output", inst_o, inst_pc_o);
      end else begin
        e = sb.pop_front();
        if ({inst_o, inst_pc_o} !== {e.inst, e.pc}) begin
          n_bad++;
          $display("FAIL sb_txn: got inst=%h pc=%h, required inst=%h pc=%h",
                   inst_o, inst_pc_o, e.inst, e.pc);
        end else begin
          $display("txn edge=%0d pc=%h inst=%h", edge_cnt, inst_pc_o, inst_o);
        end
      end
    end
  endtask

  task automatic wait_valid(input int max_ticks, output int rise_e);
    rise_e = -1;
    req_log.delete();
    gnt_log.delete();
    for (int i = 0; i < max_ticks; i++) begin
      if (skip_n > 0 && mem_req_o && mem_addr_o == skip_addr) begin
        mem_gnt_i = 1'b0;
        skip_n--;
      end else begin
        mem_gnt_i = 1'b1;
      end
      if (mem_req_o) req_log.push_back(mem_addr_o);
      if (mem_req_o && mem_gnt_i) gnt_log.push_back(mem_addr_o);
      tick();
      if (rose) begin
        rise_e = edge_cnt;
        break;
      end
    end
    mem_gnt_i = 1'b1;
    if (rise_e < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: inst_valid_o still 0 after %0d cycles, required 1", max_ticks);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b, required 0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h, required 0", mem_addr_o); end
    n_cmp++; if (inst_o !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h, required 0", inst_o); end
    n_cmp++; if (inst_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h, required 0", inst_pc_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", inst_valid_o); end
    n_cmp++; if (stall_req_o !== 1'b1) begin n_bad++; $display("FAIL rst_stall_req: got %b, required 1", stall_req_o); end
  endtask

  task automatic test_basic();
    int e0, re;
    rst = 1'b0;
    pc_i = 32'h0;
    e0 = edge_cnt + 1;
    push_exp(32'h0);
    wait_valid(30, re);
    n_cmp++; if (re != e0 + 5) begin n_bad++; $display("FAIL basic_latency: got edge %0d, required %0d", re, e0 + 5); end
    n_cmp++; if (inst_o !== 32'h00500013) begin n_bad++; $display("FAIL basic_inst: got %h, required 00500013", inst_o); end
    n_cmp++;
    if (gnt_log.size() != 4 || pack_log(gnt_log) !== 256'({32'd3, 32'd2, 32'd1, 32'd0})) begin
      n_bad++;
      $display("FAIL basic_addrs: got %0d addrs %h, required 0,1,2,3", gnt_log.size(), pack_log(gnt_log));
    end
    n_cmp++; if (stall_req_o !== 1'b0) begin n_bad++; $display("FAIL basic_stall_req: got %b, required 0", stall_req_o); end
  endtask

  task automatic test_stall_hold();
    int c, re;
    pc_i = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({inst_o, inst_pc_o, inst_valid_o, stall_req_o} !== {32'h00500013, 32'h0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL hold_stable: got inst=%h pc=%h v=%b sr=%b, required 00500013/0/1/0",
                 inst_o, inst_pc_o, inst_valid_o, stall_req_o);
      end
    end
    stall_i = 1'b0;
    c = edge_cnt + 1;
    push_exp(32'h4);
    tick();
    stall_i = 1'b1;
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL consume_valid: got %b, required 0", inst_valid_o); end
    wait_valid(30, re);
    n_cmp++; if (re != c + 5) begin n_bad++; $display("FAIL b2b_latency: got edge %0d, required %0d", re, c + 5); end
    n_cmp++;
    if (gnt_log.size() != 4 || pack_log(gnt_log) !== 256'({32'd7, 32'd6, 32'd5, 32'd4})) begin
      n_bad++;
      $display("FAIL b2b_addrs: got %0d addrs %h, required 4..7", gnt_log.size(), pack_log(gnt_log));
    end
  endtask

  task automatic test_gnt_low();
    int c, re;
    pc_i = 32'h8;
    skip_addr = 32'h9;
    skip_n = 2;
    stall_i = 1'b0;
    c = edge_cnt + 1;
    push_exp(32'h8);
    tick();
    stall_i = 1'b1;
    wait_valid(30, re);
    n_cmp++; if (re != c + 7) begin n_bad++; $display("FAIL gnt_low_latency: got edge %0d, required %0d", re, c + 7); end
    n_cmp++;
    if (req_log.size() != 6 ||
        pack_log(req_log) !== 256'({32'd11, 32'd10, 32'd9, 32'd9, 32'd9, 32'd8})) begin
      n_bad++;
      $display("FAIL gnt_low_addrs: got %0d reqs %h, required 8,9,9,9,10,11", req_log.size(), pack_log(req_log));
    end
  endtask

  task automatic test_flush();
    int e0, re;
    pc_i = 32'h20;
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_cmp++;
    if ({mem_req_o, inst_valid_o, stall_req_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL flush_outputs: got req=%b v=%b sr=%b, required 0/0/1", mem_req_o, inst_valid_o, stall_req_o);
    end
    pc_i = 32'h100;
    e0 = edge_cnt + 1;
    push_exp(32'h100);
    wait_valid(30, re);
    n_cmp++; if (re != e0 + 5) begin n_bad++; $display("FAIL flush_refetch_latency: got edge %0d, required %0d", re, e0 + 5); end
    n_cmp++;
    if (gnt_log.size() != 4 || pack_log(gnt_log) !== 256'({32'h103, 32'h102, 32'h101, 32'h100})) begin
      n_bad++;
      $display("FAIL flush_refetch_addrs: got %0d addrs %h, required 100..103", gnt_log.size(), pack_log(gnt_log));
    end
  endtask

  task automatic test_unaligned();
    int c, re;
    pc_i = 32'h106;
    stall_i = 1'b0;
    c = edge_cnt + 1;
    push_exp(32'h104);
    tick();
    stall_i = 1'b1;
    wait_valid(30, re);
    n_cmp++; if (re != c + 5) begin n_bad++; $display("FAIL unaligned_latency: got edge %0d, required %0d", re, c + 5); end
    n_cmp++;
    if (gnt_log.size() != 4 || pack_log(gnt_log) !== 256'({32'h107, 32'h106, 32'h105, 32'h104})) begin
      n_bad++;
      $display("FAIL unaligned_addrs: got %0d addrs %h, required 104..107", gnt_log.size(), pack_log(gnt_log));
    end
  endtask

  task automatic test_reset_mid();
    int e0, re;
    pc_i = 32'h300;
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_outputs: got req=%b addr=%h inst=%h pc=%h v=%b sr=%b, required 0/0/0/0/0/1",
               mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o);
    end
    rst = 1'b0;
    e0 = edge_cnt + 1;
    push_exp(32'h300);
    wait_valid(30, re);
    n_cmp++; if (re != e0 + 5) begin n_bad++; $display("FAIL midrst_latency: got edge %0d, required %0d", re, e0 + 5); end
    n_cmp++;
    if (gnt_log.size() != 4 || pack_log(gnt_log) !== 256'({32'h303, 32'h302, 32'h301, 32'h300})) begin
      n_bad++;
      $display("FAIL midrst_addrs: got %0d addrs %h, required 300..303", gnt_log.size(), pack_log(gnt_log));
    end
  endtask

  initial begin
    rst = 1'b1;
    pc_i = 32'h0;
    flush_i = 1'b0;
    stall_i = 1'b1;
    mem_gnt_i = 1'b1;
    mem_rdata_i = 8'h00;
    test_reset();
    test_basic();
    test_stall_hold();
    test_gnt_low();
    test_flush();
    test_unaligned();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
